vga_fb_ctrl: RTL and testbench
==============================

// Module: vga_fb_ctrl
// PURPOSE
//   Frame-buffer controller sitting between the VGA timing block and a single-port pixel RAM.
//   Uses the VGA counters to prefetch each scaled pixel two cycles ahead and drives the VGA rgb input.
//   Shares the single RAM port between this video fetch and one CPU write requester.
//   Video fetch has absolute priority over CPU writes.
// PARAMETERS
//   H_ACTIVE     640  visible pixels per line
//   H_TOTAL      800  pixel clocks per line
//   V_ACTIVE     480  visible lines per frame
//   V_TOTAL      525  lines per frame
//   SCALE_SHIFT  3    log2 of the screen pixels per FB cell on each axis (8x8 block -> 80x60 cells)
//   AW           13   RAM address width; must be >= clog2(COLS*ROWS)
//   COLS/ROWS are localparams: H_ACTIVE>>SCALE_SHIFT and V_ACTIVE>>SCALE_SHIFT.
// PORTS
//   clk        in   1   pixel clock, the same clock the VGA block uses
//   rst        in   1   asynchronous reset, active-low
//   iCtrH      in   10  horizontal counter from VGA (oCtrH)
//   iCtrV      in   10  vertical counter from VGA (oCtrV)
//   iWrReq     in   1   CPU write request; held high until oWrAck
//   iWrAddr    in   AW  CPU cell address, row*COLS+col
//   iWrData    in   3   CPU pixel {R,G,B}
//   oWrAck     out  1   one-cycle pulse: write accepted
//   oMemAddr   out  AW  RAM address
//   oMemWe     out  1   RAM write enable
//   oMemWData  out  3   RAM write data
//   iMemRData  in   3   RAM read data, valid 1 cycle after the address
//   oRgb       out  3   pixel to the VGA rgb input; 0 outside the active area
// BEHAVIOUR
//   Reset (rst=0, async): oWrAck=0, oMemWe=0, oMemAddr=0, oMemWData=0, pixel reg=0, oRgb=0, FSM=S_IDLE.
//   Look-ahead: hN=iCtrH+2. If hN>=H_TOTAL then hN-=H_TOTAL and vN=iCtrV+1, wrapping at V_TOTAL; else vN=iCtrV.
//   Fetch slot: hN<H_ACTIVE && vN<V_ACTIVE && hN[SCALE_SHIFT-1:0]==0.
//   In a fetch slot:
//     - oMemAddr=(vN>>S)*COLS+(hN>>S) and oMemWe=0; FSM goes to S_RD.
//     - In the next cycle the pixel reg loads iMemRData.
//     - Total latency 2: the data is shown when iCtrH==hN.
//   oRgb is combinational: pixel reg when iCtrH<H_ACTIVE && iCtrV<V_ACTIVE, else 3'b000.
//   FSM states: S_IDLE -> S_RD (fetch slot) | S_WR (write granted); S_RD/S_WR -> re-evaluated each cycle.
//     Priority each cycle: fetch slot > write grant > idle.
//   Write grant: iWrReq=1 and no fetch slot this cycle.
//     - Drives oMemAddr=iWrAddr, oMemWData=iWrData, oMemWe=1 and oWrAck=1 for exactly that cycle.
//   Collision: a write and a fetch slot in the same cycle -> the fetch wins; the write is granted on the next non-slot cycle.
//     Worst-case wait is 1 cycle when SCALE_SHIFT>=1.
//   Out of range: iWrAddr>=COLS*ROWS is still acked (oWrAck=1) but oMemWe stays 0, so the RAM is untouched.
//   Back-to-back writes: iWrReq still high the cycle after an ack is treated as a new request.
//   Reset mid-write: the request is dropped and no ack is issued; the requester must re-request after reset.
//   Counters out of range (>=H_TOTAL / V_TOTAL): no fetch slot, oRgb=0.
// CONFIGURATION
//   VGA_FB_VBLANK_WR_EN defined:
//     - Writes are granted only while iCtrV>=V_ACTIVE (vertical blank), giving tear-free updates.
//     - Outside vblank, iWrReq waits with oWrAck=0.
//   Not defined: writes are granted on any non-fetch cycle, as described above.
// STRUCTURE
//   vga_pkg (shared package):
//     - constants H_ACTIVE/H_TOTAL/V_ACTIVE/V_TOTAL and SCALE_SHIFT defaults
//     - pixel_t (3-bit {R,G,B})
//     - FSM state enum {S_IDLE,S_RD,S_WR}
//   Sub-module vga_fb_addr_gen: combinational look-ahead (hN/vN wrap), fetch-slot flag and fetch address.
//     It is instantiated once; the arbitration FSM and the pixel register stay in vga_fb_ctrl.
// TESTING
//   1 Reset: rst=0 with iWrReq=1 -> oWrAck=0, oMemWe=0, oRgb=0. After rst=1, an ack follows within 2 cycles.
//   2 Fetch: RAM cell 0=3'b100, cell 1=3'b010; counters run from (0,0).
//     -> addr 0 read at iCtrH=798 of the previous line.
//     -> oRgb=100 for H=0..7 and 010 for H=8..15 on line 0.
//   3 Collision: iWrReq asserted at iCtrH=6 (hN=8, a slot).
//     -> cycle 6: read addr 1, oWrAck=0. Cycle 7: oMemWe=1, oWrAck=1.
//   4 Wrap: iCtrH=798, iCtrV=524 -> fetch addr 0 (frame wrap). iCtrH=640..799 -> oRgb=0.
//   5 Out of range: iWrAddr=4800, iWrReq=1 -> oWrAck=1, oMemWe=0; RAM unchanged.
//   6 VGA_FB_VBLANK_WR_EN defined: iWrReq at iCtrV=100 -> no ack until iCtrV=480; the ack comes in the first non-slot cycle there.

Source files
------------

// File: rtl/vga_pkg.sv
// ----------------------------------------------------------------------------
// vga_pkg
//   Shared definitions for the VGA frame-buffer controller slice:
//     - default 640x480@60 timing constants and the frame-buffer scale shift
//     - pixel_t : 3-bit {R,G,B} pixel
//     - state_t : RAM-port arbitration state {S_IDLE, S_RD, S_WR}
// ----------------------------------------------------------------------------
package vga_pkg;

  localparam int H_ACTIVE_DEF    = 640;
  localparam int H_TOTAL_DEF     = 800;
  localparam int V_ACTIVE_DEF    = 480;
  localparam int V_TOTAL_DEF     = 525;
  localparam int SCALE_SHIFT_DEF = 3;

  typedef logic [2:0] pixel_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD,
    S_WR
  } state_t;

endpackage

// File: rtl/vga_fb_addr_gen.sv
// ----------------------------------------------------------------------------
// vga_fb_addr_gen
//   Combinational look-ahead for the frame-buffer fetch. Projects the VGA
//   counters two pixel clocks ahead (wrapping line and frame), flags the
//   cycles on which a new frame-buffer cell must be read, and forms the
//   cell address row*COLS+col of that look-ahead position.
// Ports
//   ctr_h      in   10  horizontal counter from the VGA timing block
//   ctr_v      in   10  vertical counter from the VGA timing block
//   slot       out  1   this cycle is a fetch slot
//   fetch_addr out  AW  cell address to read in a fetch slot
// ----------------------------------------------------------------------------
module vga_fb_addr_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE    = H_ACTIVE_DEF,
  parameter int H_TOTAL     = H_TOTAL_DEF,
  parameter int V_ACTIVE    = V_ACTIVE_DEF,
  parameter int V_TOTAL     = V_TOTAL_DEF,
  parameter int SCALE_SHIFT = SCALE_SHIFT_DEF,
  parameter int AW          = 13
) (
  input  logic [9:0]    ctr_h,
  input  logic [9:0]    ctr_v,
  output logic          slot,
  output logic [AW-1:0] fetch_addr
);

  localparam int COLS = H_ACTIVE >> SCALE_SHIFT;

  // 32-bit working values keep the +2 / +1 carries and the comparisons
  // against the integer timing constants free of width surprises.
  logic [31:0] h_sum;
  logic [31:0] h_n;
  logic [31:0] v_n;
  logic        ctr_in_range;

  // NOTE: every signal assigned in an always_comb gets a value on every path
  // (defaults first), otherwise synthesis infers a latch.
  always_comb begin
    h_sum = 32'(ctr_h) + 32'd2;
    h_n   = h_sum;
    v_n   = 32'(ctr_v);
    if (h_sum >= H_TOTAL) begin
      h_n = h_sum - 32'(H_TOTAL);
      v_n = (32'(ctr_v) + 32'd1 >= V_TOTAL) ? 32'd0 : 32'(ctr_v) + 32'd1;
    end
  end

  // Garbage counters must never trigger a read, even if the projected
  // position happens to land on a cell boundary.
  assign ctr_in_range = (32'(ctr_h) < H_TOTAL) && (32'(ctr_v) < V_TOTAL);

  assign slot = ctr_in_range && (h_n < H_ACTIVE) && (v_n < V_ACTIVE) &&
                (h_n[SCALE_SHIFT-1:0] == '0);

  assign fetch_addr = AW'((v_n >> SCALE_SHIFT) * COLS + (h_n >> SCALE_SHIFT));

endmodule

// File: rtl/vga_fb_ctrl.sv
// ----------------------------------------------------------------------------
// vga_fb_ctrl
//   Frame-buffer controller between the VGA timing block and a single-port
//   pixel RAM. Each scaled pixel is read two clocks before it is displayed;
//   the one RAM port is shared with a CPU write requester, and the video
//   fetch always wins. A write that loses to a fetch is granted on the next
//   cycle that is not a fetch slot.
// Configuration
//   VGA_FB_VBLANK_WR_EN : when defined, CPU writes are only granted while
//                         iCtrV >= V_ACTIVE (vertical blank).
// Ports
//   clk        in   1   pixel clock (shared with the VGA timing block)
//   rst        in   1   asynchronous reset, active-low
//   iCtrH      in   10  horizontal counter from VGA
//   iCtrV      in   10  vertical counter from VGA
//   iWrReq     in   1   CPU write request, held until oWrAck
//   iWrAddr    in   AW  CPU cell address, row*COLS+col
//   iWrData    in   3   CPU pixel {R,G,B}
//   oWrAck     out  1   one-cycle pulse: write accepted
//   oMemAddr   out  AW  RAM address
//   oMemWe     out  1   RAM write enable
//   oMemWData  out  3   RAM write data
//   iMemRData  in   3   RAM read data, valid one cycle after the address
//   oRgb       out  3   pixel to the VGA rgb input, 0 outside the active area
// ----------------------------------------------------------------------------
module vga_fb_ctrl
  import vga_pkg::*;
#(
  parameter int H_ACTIVE    = H_ACTIVE_DEF,
  parameter int H_TOTAL     = H_TOTAL_DEF,
  parameter int V_ACTIVE    = V_ACTIVE_DEF,
  parameter int V_TOTAL     = V_TOTAL_DEF,
  parameter int SCALE_SHIFT = SCALE_SHIFT_DEF,
  parameter int AW          = 13
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [9:0]    iCtrH,
  input  logic [9:0]    iCtrV,
  input  logic          iWrReq,
  input  logic [AW-1:0] iWrAddr,
  input  logic [2:0]    iWrData,
  output logic          oWrAck,
  output logic [AW-1:0] oMemAddr,
  output logic          oMemWe,
  output logic [2:0]    oMemWData,
  input  logic [2:0]    iMemRData,
  output logic [2:0]    oRgb
);

  localparam int COLS  = H_ACTIVE >> SCALE_SHIFT;
  localparam int ROWS  = V_ACTIVE >> SCALE_SHIFT;
  localparam int CELLS = COLS * ROWS;

  state_t        state;
  state_t        next_state;
  logic          slot;
  logic [AW-1:0] fetch_addr;
  logic          wr_window;
  logic          wr_grant;
  logic          wr_in_range;
  pixel_t        pixel_q;

  vga_fb_addr_gen #(
    .H_ACTIVE   (H_ACTIVE),
    .H_TOTAL    (H_TOTAL),
    .V_ACTIVE   (V_ACTIVE),
    .V_TOTAL    (V_TOTAL),
    .SCALE_SHIFT(SCALE_SHIFT),
    .AW         (AW)
  ) u_addr_gen (
    .ctr_h     (iCtrH),
    .ctr_v     (iCtrV),
    .slot      (slot),
    .fetch_addr(fetch_addr)
  );

`ifdef VGA_FB_VBLANK_WR_EN
  // Tear-free mode: the frame buffer only changes while nothing is scanned out.
  assign wr_window = (32'(iCtrV) >= V_ACTIVE);
`else
  assign wr_window = 1'b1;
`endif

  assign wr_grant    = iWrReq && wr_window && !slot;
  assign wr_in_range = (32'(iWrAddr) < CELLS);

  // State register: remembers what the RAM port did last cycle, so a read
  // issued in a fetch slot is captured when its data returns.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state: fetch slot beats a write grant, which beats idle.
  always_comb begin
    next_state = S_IDLE;
    if (slot) begin
      next_state = S_RD;
    end else if (wr_grant) begin
      next_state = S_WR;
    end
  end

  // RAM-port outputs follow this cycle's decision; while reset is asserted
  // they are held quiet so a pending request is dropped without an ack.
  always_comb begin
    oMemAddr  = '0;
    oMemWe    = 1'b0;
    oMemWData = '0;
    oWrAck    = 1'b0;
    if (rst) begin
      unique case (next_state)
        S_RD: begin
          oMemAddr = fetch_addr;
        end
        S_WR: begin
          oMemAddr  = iWrAddr;
          oMemWData = iWrData;
          oMemWe    = wr_in_range;  // out-of-range writes are acked but dropped
          oWrAck    = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Pixel register: loads the RAM data one cycle after a fetch slot, which
  // puts the pixel on screen exactly at the look-ahead position.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pixel_q <= '0;
    end else if (state == S_RD) begin
      pixel_q <= iMemRData;
    end
  end

  assign oRgb = ((32'(iCtrH) < H_ACTIVE) && (32'(iCtrV) < V_ACTIVE)) ? pixel_q : 3'b000;

endmodule

// File: tb/tb_vga_fb_ctrl.sv
// ----------------------------------------------------------------------------
// tb_vga_fb_ctrl
//   Self-checking bench for vga_fb_ctrl. The bench plays the VGA timing block
//   (it drives the counters, sometimes contiguously, sometimes jumping), a
//   CPU requester and a synchronous RAM. A behavioural model works on the
//   linear screen position: it decides fetch slots and write grants from
//   position arithmetic, keeps its own copy of the frame buffer, and predicts
//   each displayed pixel from the buffer contents at the time the counters
//   stood two clocks before the cell's first pixel.
// ----------------------------------------------------------------------------
module tb_vga_fb_ctrl;

  localparam int HA    = 640;
  localparam int HT    = 800;
  localparam int VA    = 480;
  localparam int VT    = 525;
  localparam int COLS  = 80;
  localparam int CELLS = 4800;
  localparam int AW    = 13;
  localparam int FRAME = HT * VT;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [9:0]    ctr_h = '0;
  logic [9:0]    ctr_v = '0;
  logic          wr_req = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [2:0]    wr_data = '0;
  logic          wr_ack;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [2:0]    mem_wdata;
  logic [2:0]    mem_rdata = '0;
  logic [2:0]    rgb;

  // Bench-side RAM preload port.
  logic          load_en = 1'b0;
  logic [AW-1:0] load_addr = '0;
  logic [2:0]    load_data = '0;

  // Values applied on the next tick.
  logic          nx_rst = 1'b0;
  logic          nx_req = 1'b0;
  logic [AW-1:0] nx_addr = '0;
  logic [2:0]    nx_data = '0;
  logic          nx_load = 1'b0;
  logic [AW-1:0] nx_load_addr = '0;
  logic [2:0]    nx_load_data = '0;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  vga_fb_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .iCtrH    (ctr_h),
    .iCtrV    (ctr_v),
    .iWrReq   (wr_req),
    .iWrAddr  (wr_addr),
    .iWrData  (wr_data),
    .oWrAck   (wr_ack),
    .oMemAddr (mem_addr),
    .oMemWe   (mem_we),
    .oMemWData(mem_wdata),
    .iMemRData(mem_rdata),
    .oRgb     (rgb)
  );

  // Synchronous single-port RAM with registered read data.
  logic [2:0] ram [0:8191];
  always @(posedge clk) begin
    if (load_en) ram[load_addr] <= load_data;
    else if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (h=%0d v=%0d at %0t)", name, act, exp,
               ctr_h, ctr_v, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model and per-cycle compare
  // ---------------------------------------------------------------------------
  logic [2:0] model_mem [0:CELLS-1];
  int         hist_pos [0:15];
  logic [2:0] hist_val [0:15];
  int         t = 0;
  int         m_h, m_v, m_pos, m_np, m_hn, m_vn, m_d, m_b, m_f, m_cell;
  bit         m_inr, m_slot, m_grant, m_win, m_ok;

  initial for (int i = 0; i < 16; i++) hist_pos[i] = -1;

  always @(negedge clk) begin
    m_h = int'(ctr_h);
    m_v = int'(ctr_v);
    m_inr = (m_h < HT) && (m_v < VT);
    m_slot = 1'b0;
    m_pos = -1;
    m_cell = 0;
    if (m_inr) begin
      m_pos  = m_v * HT + m_h;
      m_np   = (m_pos + 2) % FRAME;
      m_hn   = m_np % HT;
      m_vn   = m_np / HT;
      m_slot = (m_hn < HA) && (m_vn < VA) && (m_hn % 8 == 0);
      m_cell = (m_vn / 8) * COLS + (m_hn / 8);
    end
    if (!rst) begin
      check("reset_ack", wr_ack, 0);
      check("reset_we", mem_we, 0);
      check("reset_addr", mem_addr, 0);
      check("reset_rgb", rgb, 0);
      hist_pos[t % 16] = -1;
    end else begin
`ifdef VGA_FB_VBLANK_WR_EN
      m_win = (m_v >= VA);
`else
      m_win = 1'b1;
`endif
      m_grant = wr_req && m_win && !m_slot;
      if (m_slot) begin
        check("fetch_addr", mem_addr, m_cell);
        check("fetch_we", mem_we, 0);
        check("fetch_ack", wr_ack, 0);
      end else if (m_grant) begin
        check("grant_ack", wr_ack, 1);
        check("grant_addr", mem_addr, wr_addr);
        check("grant_we", mem_we, (int'(wr_addr) < CELLS) ? 1 : 0);
        if (int'(wr_addr) < CELLS) check("grant_wdata", mem_wdata, wr_data);
      end else begin
        check("idle_ack", wr_ack, 0);
        check("idle_we", mem_we, 0);
      end
      hist_pos[t % 16] = m_pos;
      hist_val[t % 16] = m_slot ? model_mem[m_cell] : 3'b000;
      if (m_inr && m_h < HA && m_v < VA) begin
        // Pixel of the cell starting at b, read when the screen stood at b-2;
        // only predictable if the counters ran without a jump since then.
        m_d  = (m_h % 8) + 2;
        m_b  = m_v * HT + (m_h - m_h % 8);
        m_f  = (m_b - 2 + FRAME) % FRAME;
        m_ok = (t >= m_d) && (hist_pos[(t - m_d) % 16] == m_f);
        for (int k = 1; k <= m_d; k++) begin
          if (m_ok && hist_pos[(t - m_d + k) % 16] != (hist_pos[(t - m_d + k - 1) % 16] + 1) % FRAME)
            m_ok = 1'b0;
        end
        if (m_ok) check("rgb_active", rgb, hist_val[(t - m_d) % 16]);
      end else begin
        check("rgb_blank", rgb, 0);
      end
      if (m_grant && int'(wr_addr) < CELLS) model_mem[wr_addr] = wr_data;
    end
    if (load_en && int'(load_addr) < CELLS) model_mem[load_addr] = load_data;
    t++;
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic tick(input int h, input int v);
    @(posedge clk);
    #1;
    rst       = nx_rst;
    wr_req    = nx_req;
    wr_addr   = nx_addr;
    wr_data   = nx_data;
    load_en   = nx_load;
    load_addr = nx_load_addr;
    load_data = nx_load_data;
    ctr_h     = 10'(h);
    ctr_v     = 10'(v);
    @(negedge clk);
  endtask

  task automatic adv(inout int h, inout int v);
    h++;
    if (h == HT) begin
      h = 0;
      v = (v + 1) % VT;
    end
  endtask

  task automatic poke(input int a, input logic [2:0] d);
    nx_load      = 1'b1;
    nx_load_addr = AW'(a);
    nx_load_data = d;
    tick(810, 0);
    nx_load = 1'b0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int  h, v, len;
  bit  seen;
  int  ack_h, ack_v;

  initial begin
    // Preload RAM while reset is held.
    for (int c = 0; c < CELLS; c++) poke(c, 3'($urandom_range(0, 7)));
    poke(4800, 3'b001);
    tick(810, 0);

    // 1: reset with a pending request, then release.
    nx_req  = 1'b1;
    nx_addr = AW'(5);
    nx_data = 3'b011;
    tick(100, 10);
    check("t1_ack_in_reset", wr_ack, 0);
    check("t1_we_in_reset", mem_we, 0);
    check("t1_rgb_in_reset", rgb, 0);
    nx_rst = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 2 && !seen; i++) begin
      tick(101 + i, 10);
      if (wr_ack) seen = 1'b1;
    end
    check("t1_ack_after_reset", seen, 1);
    nx_req = 1'b0;
    tick(110, 10);

    // 2: fetch of cells 0 and 1 around the frame wrap.
    poke(0, 3'b100);
    poke(1, 3'b010);
    h = 780;
    v = 524;
    while (!(h == 20 && v == 0)) begin
      tick(h, v);
      if (h == 798 && v == 524) begin
        check("t2_addr_at_798", mem_addr, 0);
        check("t2_we_at_798", mem_we, 0);
      end
      if (v == 0 && h < 8) check("t2_rgb_cell0", rgb, 3'b100);
      if (v == 0 && h >= 8 && h < 16) check("t2_rgb_cell1", rgb, 3'b010);
      adv(h, v);
    end

    // 4: horizontal blank is black; 3: collision at iCtrH=6 of line 1.
    while (!(h == 6 && v == 1)) begin
      tick(h, v);
      if (h >= HA) check("t4_rgb_hblank", rgb, 0);
      adv(h, v);
    end
    nx_req  = 1'b1;
    nx_addr = AW'(100);
    nx_data = 3'b101;
    tick(6, 1);
    check("t3_slot_addr", mem_addr, 1);
    check("t3_slot_ack", wr_ack, 0);
    check("t3_slot_we", mem_we, 0);
    tick(7, 1);
    check("t3_late_we", mem_we, 1);
    check("t3_late_ack", wr_ack, 1);
    check("t3_late_addr", mem_addr, 100);
    nx_req = 1'b0;
    h = 8;
    while (h < 20) begin
      tick(h, 1);
      h++;
    end

    // 5: out-of-range address is acked but not written.
    nx_req  = 1'b1;
    nx_addr = AW'(4800);
    nx_data = 3'b110;
    tick(20, 1);
    check("t5_oor_ack", wr_ack, 1);
    check("t5_oor_we", mem_we, 0);
    nx_req = 1'b0;
    tick(21, 1);
    tick(22, 1);
    check("t5_ram_untouched", ram[4800], 3'b001);

`ifdef VGA_FB_VBLANK_WR_EN
    // 6: requests wait for vertical blank.
    nx_req  = 1'b1;
    nx_addr = AW'(200);
    nx_data = 3'b010;
    h = 700;
    v = 100;
    for (int i = 0; i < 40; i++) begin
      tick(h, v);
      check("t6_no_ack_active", wr_ack, 0);
      adv(h, v);
    end
    h = 790;
    v = 479;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick(h, v);
      if (wr_ack) begin
        seen  = 1'b1;
        ack_h = h;
        ack_v = v;
      end
      adv(h, v);
    end
    check("t6_ack_seen", seen, 1);
    if (seen) begin
      check("t6_ack_line", ack_v, 480);
      check("t6_ack_col", ack_h, 0);
    end
    nx_req = 1'b0;
`endif

    // Randomized segments: contiguous runs from random positions, random
    // requests (some out of range), occasional reset pulses.
    for (int seg = 0; seg < 40; seg++) begin
      h   = $urandom_range(0, HT + 5);
      v   = $urandom_range(0, VT + 3);
      len = $urandom_range(100, 500);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 299) == 0) nx_rst = 1'b0;
        tick(h, v);
        nx_rst = 1'b1;
        if (wr_ack || !nx_req) begin
          if (wr_ack || $urandom_range(0, 3) == 0) begin
            nx_req  = ($urandom_range(0, 1) == 1);
            nx_addr = ($urandom_range(0, 15) == 0) ? AW'(CELLS + $urandom_range(0, 50))
                                                   : AW'($urandom_range(0, CELLS - 1));
            nx_data = 3'($urandom_range(0, 7));
          end
        end
        if (h >= HT || v >= VT) begin
          h = $urandom_range(0, HT - 1);
          v = $urandom_range(0, VT - 1);
        end else begin
          adv(h, v);
        end
      end
    end

    // Final RAM image must equal the model's frame buffer.
    nx_req = 1'b0;
    nx_rst = 1'b1;
    tick(810, 0);
    tick(810, 0);
    for (int c = 0; c < CELLS; c++) check("ram_image", ram[c], model_mem[c]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
